// File: rtl/startup_seq_ctrl.sv
// rtl/startup_seq_ctrl.sv - STARTUPE2 user-side sequencer: dummy CCLK pulses, user reset release, PROGRAM handshake
//
// Ports:
//   CLK, RST          fabric clock, synchronous active-high reset
//   EOS, PREQ         End Of Startup / PROGRAM request from the primitive (asynchronous)
//   USR_PACK_OK       user logic permits reconfiguration
//   SPI_REQ, SPI_CCLK user CCLK ownership request and level (honoured only once READY)
//   USRCCLKO          CCLK level driven into the primitive
//   USRCCLKTS         CCLK tristate control, 1 = tristated
//   PACK              PROGRAM acknowledge to the primitive
//   USR_RST           active-high reset to user logic
//   READY             startup sequence complete
//   PROG_PENDING      PROGRAM request outstanding
module startup_seq_ctrl #(
    parameter int CCLK_DIV     = 4,
    parameter int DUMMY_PULSES = 3,
    parameter int RST_HOLD     = 16,
    parameter int PACK_TIMEOUT = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic EOS,
    input  logic PREQ,
    input  logic USR_PACK_OK,
    input  logic SPI_REQ,
    input  logic SPI_CCLK,
    output logic USRCCLKO,
    output logic USRCCLKTS,
    output logic PACK,
    output logic USR_RST,
    output logic READY,
    output logic PROG_PENDING
);

    // One phase counter serves both the pulse half-periods and the reset hold.
    localparam int CNT_MAX = (CCLK_DIV > RST_HOLD) ? CCLK_DIV : RST_HOLD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PW      = (DUMMY_PULSES > 1) ? $clog2(DUMMY_PULSES) : 1;
    localparam int TW      = $clog2(PACK_TIMEOUT);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CCLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(DUMMY_PULSES - 1);
    localparam logic [TW-1:0] T_LAST     = TW'(PACK_TIMEOUT - 1);

    typedef enum logic [2:0] {WAIT_EOS, DUMMY_HI, DUMMY_LO, HOLD, RUN} main_t;
    typedef enum logic [1:0] {P_IDLE, P_WAIT, P_ACK} preq_t;

    logic          eos_m, eos_s, preq_m, preq_s;
    main_t         state_q, state_d;
    preq_t         pstate_q, pstate_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          cclko_d, cclkts_d, pack_d, usr_rst_d, ready_d, pend_d;

    // State, counter, synchronizer and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            eos_m        <= 1'b0;
            eos_s        <= 1'b0;
            preq_m       <= 1'b0;
            preq_s       <= 1'b0;
            state_q      <= WAIT_EOS;
            pstate_q     <= P_IDLE;
            cnt_q        <= '0;
            pcnt_q       <= '0;
            tcnt_q       <= '0;
            USRCCLKO     <= 1'b0;
            USRCCLKTS    <= 1'b1;
            PACK         <= 1'b0;
            USR_RST      <= 1'b1;
            READY        <= 1'b0;
            PROG_PENDING <= 1'b0;
        end else begin
            eos_m        <= EOS;
            eos_s        <= eos_m;
            preq_m       <= PREQ;
            preq_s       <= preq_m;
            state_q      <= state_d;
            pstate_q     <= pstate_d;
            cnt_q        <= cnt_d;
            pcnt_q       <= pcnt_d;
            tcnt_q       <= tcnt_d;
            USRCCLKO     <= cclko_d;
            USRCCLKTS    <= cclkts_d;
            PACK         <= pack_d;
            USR_RST      <= usr_rst_d;
            READY        <= ready_d;
            PROG_PENDING <= pend_d;
        end
    end

    // Main sequence next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            WAIT_EOS: begin
                cnt_d  = '0;
                pcnt_d = '0;
                if (eos_s) state_d = DUMMY_HI;
            end
            DUMMY_HI: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = DUMMY_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DUMMY_LO: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (pcnt_q == PULSE_LAST) begin
                        state_d = HOLD;
                    end else begin
                        pcnt_d  = pcnt_q + PW'(1);
                        state_d = DUMMY_HI;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = WAIT_EOS;
        endcase
        // Loss of EOS anywhere past WAIT_EOS aborts the sequence.
        if (state_q != WAIT_EOS && !eos_s) begin
            state_d = WAIT_EOS;
            cnt_d   = '0;
            pcnt_d  = '0;
        end
    end

    // Main sequence outputs, decoded from the next state so they register in step with it.
    always_comb begin
        cclko_d   = 1'b0;
        cclkts_d  = 1'b1;
        usr_rst_d = 1'b1;
        ready_d   = 1'b0;
        case (state_d)
            DUMMY_HI: begin
                cclko_d  = 1'b1;
                cclkts_d = 1'b0;
            end
            DUMMY_LO, HOLD: cclkts_d = 1'b0;
            RUN: begin
                cclko_d   = SPI_CCLK;
                cclkts_d  = ~SPI_REQ;
                usr_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            default: cclko_d = 1'b0;
        endcase
    end

    // PROGRAM handshake next state. Outside RUN there is no user logic to protect,
    // so the acknowledge is immediate.
    always_comb begin
        pstate_d = pstate_q;
        tcnt_d   = tcnt_q;
        case (pstate_q)
            P_IDLE: begin
                tcnt_d = '0;
                if (preq_s) pstate_d = P_WAIT;
            end
            P_WAIT: begin
                if (!preq_s) begin
                    pstate_d = P_IDLE;
                end else if (USR_PACK_OK || (state_q != RUN) || (tcnt_q == T_LAST)) begin
                    pstate_d = P_ACK;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            P_ACK: begin
                if (!preq_s) pstate_d = P_IDLE;
            end
            default: pstate_d = P_IDLE;
        endcase
    end

    // PROGRAM handshake outputs.
    always_comb begin
        pack_d = (pstate_d == P_ACK);
        pend_d = (pstate_d != P_IDLE);
    end

endmodule
